// File: rtl/mda_char_shifter_pkg.sv
// mda_char_shifter_pkg: shared state enum, MDA geometry and attribute bit positions.
package mda_char_shifter_pkg;
    typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE} state_t;
    localparam int MDA_COLS    = 80;
    localparam int MDA_ROWS    = 25;
    localparam int CELL_W      = 9;
    localparam int CELL_H      = 14;
    localparam int ACTIVE_DOTS = MDA_COLS * CELL_W;
    localparam int ATTR_INTENSE = 3;
    localparam int ATTR_BLINK   = 7;
    localparam logic [3:0] DOT_FONT  = 4'd5;
    localparam logic [3:0] DOT_STAGE = 4'd6;
endpackage

// File: rtl/mda_char_shifter_attr_decode.sv
// mda_attr_decode: MDA attribute, blink and underline decode for one dot.
module mda_attr_decode
    import mda_char_shifter_pkg::*;
(
    input  logic [7:0] attr_i,
    input  logic       glyph_i,
    input  logic       ul_scan_i,
    input  logic       blink_phase_i,
    output logic       fg_on_o,
    output logic       bg_on_o,
    output logic       intense_o
);
    logic blank, reverse, glyph, hide;
    always_comb begin
        blank     = attr_i[6:4] == 3'd0 && attr_i[2:0] == 3'd0;
        reverse   = attr_i[6:4] == 3'd7 && attr_i[2:0] == 3'd0;
        glyph     = glyph_i | (attr_i[2:0] == 3'd1 && ul_scan_i);
        hide      = attr_i[ATTR_BLINK] & ~blink_phase_i;
        // a hidden foreground in reverse leaves only the lit background
        bg_on_o   = reverse & (hide | ~glyph);
        fg_on_o   = ~blank & ~reverse & glyph & ~hide;
        intense_o = attr_i[ATTR_INTENSE] & (fg_on_o | bg_on_o);
    end
endmodule

// File: rtl/mda_char_shifter.sv
// mda_char_shifter: MDA text-mode line fetch, 9-dot shifter and registered pixel output.
module mda_char_shifter
    import mda_char_shifter_pkg::*;
#(
    parameter int COLS    = MDA_COLS,
    parameter int CHAR_W  = CELL_W,
    parameter int UL_SCAN = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [3:0]  scan,
    input  logic        blink_phase,
    output logic [6:0]  col,
    output logic        add_one,
    input  logic [7:0]  r_code,
    input  logic [7:0]  r_attr,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        de_out,
    output logic        vid,
    output logic        intense
);
    state_t      state_q, state_d;
    logic [3:0]  dot_q, dot_d;
    logic [6:0]  char_q, char_d;
    logic [11:0] font_addr_q;
    logic [7:0]  attr_p_q, attr_s_q, attr_c_q, glyph_q;
    logic        dup_p_q, dup_s_q;
    logic [8:0]  shift_q;
    logic        de_q, vid_q, int_q;
    logic        dot_last, last_char, fetch, load, de_d, fg_on, bg_on, int_on;

    assign dot_last  = dot_q == 4'(CHAR_W - 1);
    assign last_char = char_q == 7'(COLS - 1);
    assign fetch     = state_q == PREFETCH || (state_q == ACTIVE && !last_char);
    assign load      = state_q != IDLE && dot_last;
    assign col       = state_q == ACTIVE ? char_q : 7'd0;
    assign add_one   = state_q == ACTIVE && !last_char;
    assign font_addr = (fetch && dot_q == DOT_FONT) ? {r_code, scan} : font_addr_q;
    assign de_d      = state_q == ACTIVE && !line_start;
    assign de_out    = de_q;
    assign vid       = vid_q;
    assign intense   = int_q;

    always_comb begin
        state_d = state_q;
        dot_d   = dot_last ? 4'd0 : dot_q + 4'd1;
        char_d  = char_q;
        case (state_q)
            IDLE: begin
                dot_d  = 4'd0;
                char_d = 7'd0;
            end
            PREFETCH: state_d = dot_last ? ACTIVE : PREFETCH;
            ACTIVE: if (dot_last) begin
                state_d = last_char ? IDLE : ACTIVE;
                char_d  = last_char ? 7'd0 : char_q + 7'd1;
            end
            default: state_d = IDLE;
        endcase
        // a new line_start always wins, including mid-line restarts
        if (line_start) begin
            state_d = PREFETCH;
            dot_d   = 4'd0;
            char_d  = 7'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dot_q       <= 4'd0;
            char_q      <= 7'd0;
            font_addr_q <= 12'd0;
            attr_p_q    <= 8'd0;
            attr_s_q    <= 8'd0;
            attr_c_q    <= 8'd0;
            glyph_q     <= 8'd0;
            dup_p_q     <= 1'b0;
            dup_s_q     <= 1'b0;
            shift_q     <= 9'd0;
            de_q        <= 1'b0;
            vid_q       <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dot_q       <= dot_d;
            char_q      <= char_d;
            font_addr_q <= font_addr;
            if (fetch && dot_q == DOT_FONT) begin
                attr_p_q <= r_attr;
                dup_p_q  <= r_code[7:5] == 3'b110;
            end
            if (fetch && dot_q == DOT_STAGE) begin
                glyph_q  <= font_data;
                attr_s_q <= attr_p_q;
                dup_s_q  <= dup_p_q;
            end
            shift_q  <= load ? {glyph_q, dup_s_q & glyph_q[0]} : shift_q << 1;
            attr_c_q <= load ? attr_s_q : attr_c_q;
            de_q     <= de_d;
            vid_q    <= de_d & (fg_on | bg_on);
            int_q    <= de_d & int_on;
        end
    end

    mda_attr_decode u_decode (
        .attr_i        (attr_c_q),
        .glyph_i       (shift_q[8]),
        .ul_scan_i     (scan == 4'(UL_SCAN)),
        .blink_phase_i (blink_phase),
        .fg_on_o       (fg_on),
        .bg_on_o       (bg_on),
        .intense_o     (int_on)
    );
endmodule
